// File: rtl/simon_pkg.sv
// Shared types and helpers for the iterative Simon engine.
// Holds the FSM state enum, default rotations and the rotl / f helpers.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_ROT_A = 1;
    localparam int DEF_ROT_B = 8;
    localparam int DEF_ROT_C = 2;

    // Widest legal Simon word; narrower words live in the low bits.
    localparam int MAX_W = 64;

    // Left rotation of the low w bits of v by r (r < w); upper bits forced to 0.
    function automatic logic [MAX_W-1:0] simon_rotl(
        input logic [MAX_W-1:0] v,
        input int               w,
        input int               r
    );
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] vm;
        // Shifting by the full width yields zero, so w=MAX_W gives all ones.
        m  = (MAX_W'(1) << w) - MAX_W'(1);
        vm = v & m;
        return ((vm << r) | (vm >> (w - r))) & m;
    endfunction

    function automatic logic [MAX_W-1:0] simon_f(
        input logic [MAX_W-1:0] v,
        input int               w,
        input int               ra,
        input int               rb,
        input int               rc
    );
        return (simon_rotl(v, w, ra) & simon_rotl(v, w, rb))
             ^ simon_rotl(v, w, rc);
    endfunction

endpackage

// File: rtl/simon_round.sv
// Combinational single Simon encrypt round: x_o = y_i ^ f(x_i) ^ k_i, y_o = x_i.
// Ports: x_i/y_i state words in, k_i round key, x_o/y_o next state words.
module simon_round
    import simon_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int ROT_A  = DEF_ROT_A,
    parameter int ROT_B  = DEF_ROT_B,
    parameter int ROT_C  = DEF_ROT_C
) (
    input  logic [WORD_W-1:0] x_i,
    input  logic [WORD_W-1:0] y_i,
    input  logic [WORD_W-1:0] k_i,
    output logic [WORD_W-1:0] x_o,
    output logic [WORD_W-1:0] y_o
);

    logic [WORD_W-1:0] w_f;

    assign w_f = WORD_W'(simon_f(MAX_W'(x_i), WORD_W, ROT_A, ROT_B, ROT_C));
    assign x_o = y_i ^ w_f ^ k_i;
    assign y_o = x_i;

endmodule

// File: rtl/simon_iter_core.sv
// Iterative Simon block cipher: one round per clock, valid/ready on both sides,
// round keys fetched combinationally through rk_idx_o / rk_i.
// Ports: clk, rst (sync, active high), in_valid_i/in_ready_o/pt_i plaintext side,
// rk_idx_o/rk_i key store, out_valid_o/out_ready_i/ct_o result side, busy_o.
// Optional macro SIMON_DECRYPT_EN adds mode_i (1 = decrypt, latched on accept).
module simon_iter_core
    import simon_pkg::*;
#(
    parameter  int WORD_W = 64,
    parameter  int ROUNDS = 68,
    parameter  int ROT_A  = DEF_ROT_A,
    parameter  int ROT_B  = DEF_ROT_B,
    parameter  int ROT_C  = DEF_ROT_C,
    localparam int RK_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*WORD_W-1:0] pt_i,
`ifdef SIMON_DECRYPT_EN
    input  logic                mode_i,
`endif
    output logic [RK_W-1:0]     rk_idx_o,
    input  logic [WORD_W-1:0]   rk_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [2*WORD_W-1:0] ct_o,
    output logic                busy_o
);

    localparam logic [RK_W-1:0] LAST = RK_W'(ROUNDS - 1);

    state_t            r_state;
    logic [WORD_W-1:0] r_x;
    logic [WORD_W-1:0] r_y;
    logic [RK_W-1:0]   r_rnd;

    logic              w_dec;
    logic              w_last;
    logic [WORD_W-1:0] w_rx;
    logic [WORD_W-1:0] w_ry;
    logic [WORD_W-1:0] w_ex;
    logic [WORD_W-1:0] w_ey;
    logic [WORD_W-1:0] w_nx;
    logic [WORD_W-1:0] w_ny;

`ifdef SIMON_DECRYPT_EN
    logic r_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec <= 1'b0;
        end else if (r_state == ST_IDLE && in_valid_i) begin
            r_dec <= mode_i;
        end
    end

    assign w_dec = r_dec;
`else
    assign w_dec = 1'b0;
`endif

    // Decrypt is the encrypt round applied to swapped words, swapped back.
    assign w_rx = w_dec ? r_y : r_x;
    assign w_ry = w_dec ? r_x : r_y;

    simon_round #(
        .WORD_W (WORD_W),
        .ROT_A  (ROT_A),
        .ROT_B  (ROT_B),
        .ROT_C  (ROT_C)
    ) u_round (
        .x_i (w_rx),
        .y_i (w_ry),
        .k_i (rk_i),
        .x_o (w_ex),
        .y_o (w_ey)
    );

    assign w_nx = w_dec ? w_ey : w_ex;
    assign w_ny = w_dec ? w_ex : w_ey;

    // rnd stops at LAST so DONE keeps showing the final index.
    assign w_last = (r_rnd == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_rnd   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_x     <= pt_i[2*WORD_W-1:WORD_W];
                        r_y     <= pt_i[WORD_W-1:0];
                        r_rnd   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_x <= w_nx;
                    r_y <= w_ny;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_rnd <= r_rnd + RK_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (r_state == ST_IDLE);
    assign out_valid_o = (r_state == ST_DONE);
    assign busy_o      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign ct_o        = {r_x, r_y};
    assign rk_idx_o    = (r_state == ST_IDLE) ? '0
                       : (w_dec ? (LAST - r_rnd) : r_rnd);

endmodule

// File: tb/tb_simon_iter_core.sv
// Scoreboard bench for simon_iter_core: known vectors, random blocks vs a
// behavioural Simon model, backpressure, mid-run reset and ROUNDS=1.
module tb_simon_iter_core;

    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] kx [0:67];

    // main instance: 128/128
    logic         iv, ir, ov, ordy, bsy, md;
    logic [127:0] pt, ct;
    logic [6:0]   idx;
    logic [63:0]  rk;
    assign rk = kx[idx];

    // 32/64 instance
    logic         iv16, ir16, ov16, or16, b16, md16;
    logic [31:0]  pt16, ct16;
    logic [4:0]   idx16;
    logic [15:0]  rk16;
    assign rk16 = kx[idx16][15:0];

    // single-round instance
    logic         iv1, ir1, ov1, or1, b1, md1;
    logic [127:0] pt1, ct1;
    logic [0:0]   idx1;
    logic [63:0]  rk1;
    assign rk1 = kx[idx1];

    logic [127:0] q_main [$];
    logic [31:0]  q16 [$];
    logic [127:0] q1 [$];

    simon_iter_core #(.WORD_W(64), .ROUNDS(68)) u_dut (
        .clk(clk), .rst(rst), .in_valid_i(iv), .in_ready_o(ir), .pt_i(pt),
`ifdef SIMON_DECRYPT_EN
        .mode_i(md),
`endif
        .rk_idx_o(idx), .rk_i(rk), .out_valid_o(ov), .out_ready_i(ordy),
        .ct_o(ct), .busy_o(bsy)
    );

    simon_iter_core #(.WORD_W(16), .ROUNDS(32)) u_d16 (
        .clk(clk), .rst(rst), .in_valid_i(iv16), .in_ready_o(ir16), .pt_i(pt16),
`ifdef SIMON_DECRYPT_EN
        .mode_i(md16),
`endif
        .rk_idx_o(idx16), .rk_i(rk16), .out_valid_o(ov16), .out_ready_i(or16),
        .ct_o(ct16), .busy_o(b16)
    );

    simon_iter_core #(.WORD_W(64), .ROUNDS(1)) u_r1 (
        .clk(clk), .rst(rst), .in_valid_i(iv1), .in_ready_o(ir1), .pt_i(pt1),
`ifdef SIMON_DECRYPT_EN
        .mode_i(md1),
`endif
        .rk_idx_o(idx1), .rk_i(rk1), .out_valid_o(ov1), .out_ready_i(or1),
        .ct_o(ct1), .busy_o(b1)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] msk(int n);
        return (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] rol(logic [63:0] v, int n, int r);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < n; i++)
            if (v[i]) o |= 64'd1 << ((i + r) % n);
        return o;
    endfunction

    function automatic logic [63:0] ff(logic [63:0] v, int n);
        return (rol(v, n, 1) & rol(v, n, 8)) ^ rol(v, n, 2);
    endfunction

    function automatic logic [127:0] model(logic [127:0] b, int n, int nr, bit dec);
        logic [63:0] x, y, t, m;
        m = msk(n);
        x = 64'(b >> n) & m;
        y = b[63:0] & m;
        if (!dec) begin
            for (int i = 0; i < nr; i++) begin
                t = x;
                x = (y ^ ff(x, n) ^ kx[i]) & m;
                y = t;
            end
        end else begin
            for (int i = nr - 1; i >= 0; i--) begin
                t = y;
                y = (x ^ ff(y, n) ^ kx[i]) & m;
                x = t;
            end
        end
        return (128'(x) << n) | 128'(y);
    endfunction

    task automatic expand(int n, int m, logic [61:0] zs, int nr);
        logic [63:0] t, mk, zb;
        mk = msk(n);
        for (int i = m; i < nr; i++) begin
            t = rol(kx[i-1], n, n - 3);
            if (m == 4) t ^= kx[i-3];
            t ^= rol(t, n, n - 1);
            zb = 64'((zs >> (61 - ((i - m) % 62))) & 62'd1);
            kx[i] = (~kx[i-m] & mk) ^ t ^ zb ^ 64'd3;
        end
    endtask

    task automatic rand_keys(int n);
        for (int i = 0; i < 68; i++)
            kx[i] = {$urandom, $urandom} & msk(n);
    endtask

    task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    task automatic tmo(string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && ov && ordy) begin
            if (q_main.size() == 0) tmo("ct_main_spurious");
            else chk("ct_main", ct, q_main.pop_front());
        end
        if (!rst && ov16 && or16) begin
            if (q16.size() == 0) tmo("ct_16_spurious");
            else chk("ct_16", 128'(ct16), 128'(q16.pop_front()));
        end
        if (!rst && ov1 && or1) begin
            if (q1.size() == 0) tmo("ct_r1_spurious");
            else chk("ct_r1", ct1, q1.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic send(logic [127:0] p, bit dec);
        int n = 0;
        while (!ir && n < 400) begin @(posedge clk); #1; n++; end
        if (!ir) tmo("in_ready_main");
        pt = p; md = dec; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic wait_idle(bit rnd_ready);
        int n = 0;
        while (!ir && n < 400) begin
            if (rnd_ready) ordy = 1'($urandom);
            @(posedge clk); #1; n++;
        end
        if (!ir) tmo("idle_main");
        ordy = 1'b1;
    endtask

    task automatic send16(logic [31:0] p);
        int n = 0;
        while (!ir16 && n < 400) begin @(posedge clk); #1; n++; end
        if (!ir16) tmo("in_ready_16");
        pt16 = p; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        n = 0;
        while (!ir16 && n < 400) begin @(posedge clk); #1; n++; end
        if (!ir16) tmo("idle_16");
    endtask

    task automatic send1(logic [127:0] p);
        int n = 0;
        while (!ir1 && n < 50) begin @(posedge clk); #1; n++; end
        if (!ir1) tmo("in_ready_r1");
        pt1 = p; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] e, p;
        iv = 0; ordy = 1; md = 0; pt = '0;
        iv16 = 0; or16 = 1; md16 = 0; pt16 = '0;
        iv1 = 0; or1 = 1; md1 = 0; pt1 = '0;
        for (int i = 0; i < 68; i++) kx[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", ir, 1'b1);
        chk("rst_out_valid", ov, 1'b0);
        chk("rst_ct", ct, '0);
        chk("rst_rk_idx", idx, '0);
        chk("rst_busy", bsy, 1'b0);
        rst = 0;

        // 128/128 known vector with index sequence and latency
        kx[0] = 64'h0706050403020100;
        kx[1] = 64'h0f0e0d0c0b0a0908;
        expand(64, 2, Z2, 68);
        q_main.push_back(128'h49681b1e1e54fe3f65aa832af84e0bbc);
        send(128'h63736564207372656c6c657661727420, 1'b0);
        for (int j = 0; j < 68; j++) begin
            chk("vec_rk_idx", idx, 128'(j));
            chk("vec_no_valid", ov, 1'b0);
            chk("vec_busy", bsy, 1'b1);
            @(posedge clk); #1;
        end
        chk("vec_valid_lat", ov, 1'b1);
        wait_idle(1'b0);

        // backpressure in DONE
        ordy = 0;
        p = {$urandom, $urandom, $urandom, $urandom};
        e = model(p, 64, 68, 1'b0);
        q_main.push_back(e);
        send(p, 1'b0);
        begin
            int n = 0;
            while (!ov && n < 200) begin @(posedge clk); #1; n++; end
            if (!ov) tmo("bp_valid");
        end
        for (int k = 0; k < 10; k++) begin
            iv = 1'(k % 2);
            pt = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk("bp_valid", ov, 1'b1);
            chk("bp_ct", ct, e);
            chk("bp_in_ready", ir, 1'b0);
        end
        iv = 1; ordy = 1;
        @(posedge clk); #1;
        iv = 0;
        chk("bp_release_idle", ir, 1'b1);
        chk("bp_release_busy", bsy, 1'b0);

        // reset in the middle of a block
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rk_idx", idx, 128'(30));
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("mid_in_ready", ir, 1'b1);
        chk("mid_out_valid", ov, 1'b0);
        chk("mid_ct", ct, '0);
        chk("mid_busy", bsy, 1'b0);
        chk("mid_rk_idx0", idx, '0);
        p = {$urandom, $urandom, $urandom, $urandom};
        q_main.push_back(model(p, 64, 68, 1'b0));
        send(p, 1'b0);
        wait_idle(1'b0);

        // random blocks, random keys, random downstream stalls
        for (int b = 0; b < 20; b++) begin
            bit dec;
`ifdef SIMON_DECRYPT_EN
            dec = 1'($urandom);
`else
            dec = 1'b0;
`endif
            rand_keys(64);
            p = {$urandom, $urandom, $urandom, $urandom};
            q_main.push_back(model(p, 64, 68, dec));
            send(p, dec);
            wait_idle(1'b1);
        end

`ifdef SIMON_DECRYPT_EN
        kx[0] = 64'h0706050403020100;
        kx[1] = 64'h0f0e0d0c0b0a0908;
        expand(64, 2, Z2, 68);
        q_main.push_back(128'h63736564207372656c6c657661727420);
        send(128'h49681b1e1e54fe3f65aa832af84e0bbc, 1'b1);
        for (int j = 0; j < 68; j++) begin
            chk("dec_rk_idx", idx, 128'(67 - j));
            @(posedge clk); #1;
        end
        wait_idle(1'b0);
        md = 0;
`endif

        // 32/64 known vector and a random block
        kx[0] = 64'h0100;
        kx[1] = 64'h0908;
        kx[2] = 64'h1110;
        kx[3] = 64'h1918;
        expand(16, 4, Z0, 32);
        q16.push_back(32'hc69be9bb);
        send16(32'h65656877);
        rand_keys(16);
        pt16 = $urandom;
        q16.push_back(32'(model(128'(pt16), 16, 32, 1'b0)));
        send16(pt16);

        // single round
        kx[0] = {16{4'hA, 4'h5}} ;
        q1.push_back({{16{4'hA, 4'h5}}, 64'h0});
        send1('0);
        chk("r1_no_valid", ov1, 1'b0);
        chk("r1_rk_idx", idx1, 1'b0);
        @(posedge clk); #1;
        chk("r1_valid", ov1, 1'b1);
        @(posedge clk); #1;
        kx[0] = {$urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        q1.push_back(model(p, 64, 1, 1'b0));
        send1(p);
        repeat (4) @(posedge clk);
        #1;

        chk("q_main_empty", q_main.size(), 0);
        chk("q16_empty", q16.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
